pacman_sprite_engine: RTL and testbench

//  Parametrised, pipelined sprite pixel generator; successor to the fixed solid-box tile graphic.

---
 rtl/pacman_sprite_engine.sv | 160 ++++++++++++++++
 tb/tb_pacman_sprite_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_sprite_engine.sv
// Two-stage sprite pixel generator: box, animated Pac-Man, pellet and transparent tiles.
// Owns the global mouth-animation frame counter shared by every Pac-Man request.
module pacman_sprite_engine #(
    parameter int unsigned PIXELS_WIDTH     = 16,
    parameter int unsigned REL_BITS         = 4,
    parameter int unsigned PIXEL_COLOR_BITS = 8,
    parameter int unsigned NUM_FRAMES       = 4,
    parameter int unsigned FRAME_TICKS      = 8,
    parameter logic [PIXEL_COLOR_BITS-1:0] COLOR_BOX    = 8'b00111000,
    parameter logic [PIXEL_COLOR_BITS-1:0] COLOR_PAC    = 8'b11111100,
    parameter logic [PIXEL_COLOR_BITS-1:0] COLOR_PELLET = 8'b11111111,
    parameter logic [PIXEL_COLOR_BITS-1:0] COLOR_BG     = 8'b00000000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                anim_tick,
    input  logic                                anim_en,
    input  logic [1:0]                          dir,
    input  logic [1:0]                          sprite_sel,
    input  logic                                req_valid,
    input  logic [REL_BITS-1:0]                 x,
    input  logic [REL_BITS-1:0]                 y,
    output logic                                pix_valid,
    output logic [PIXEL_COLOR_BITS-1:0]         pixels,
    output logic [$clog2(NUM_FRAMES)-1:0]       frame
);

    localparam int unsigned C_W     = REL_BITS + 2;
    localparam int unsigned SQ_W    = 2 * C_W;
    localparam int unsigned FRAME_W = $clog2(NUM_FRAMES);
    localparam int unsigned TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [SQ_W-1:0] R2_DISC   = SQ_W'(PIXELS_WIDTH * PIXELS_WIDTH);
    localparam logic [SQ_W-1:0] R2_PELLET = SQ_W'((PIXELS_WIDTH / 2) * (PIXELS_WIDTH / 2));

    localparam logic [1:0] SEL_BOX    = 2'd0;
    localparam logic [1:0] SEL_PAC    = 2'd1;
    localparam logic [1:0] SEL_PELLET = 2'd2;

    // ---------------------------------------------------------------
    // Animation counters
    // ---------------------------------------------------------------
    logic [TICK_W-1:0]  tick_q,  tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    always_comb begin
        tick_d  = tick_q;
        frame_d = frame_q;
        if (anim_tick && anim_en) begin
            if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
                tick_d  = '0;
                frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            frame_q <= '0;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign frame = frame_q;

    // ---------------------------------------------------------------
    // Stage 1: centre the coordinates and rotate into the heading-right frame
    // ---------------------------------------------------------------
    logic signed [C_W-1:0] cx_c, cy_c, u_c, v_c;

    assign cx_c = signed'(C_W'({x, 1'b0})) - signed'(C_W'(PIXELS_WIDTH - 1));
    assign cy_c = signed'(C_W'({y, 1'b0})) - signed'(C_W'(PIXELS_WIDTH - 1));

    always_comb begin
        u_c = cx_c;
        v_c = cy_c;
        case (dir)
            2'd1:    begin u_c = -cy_c; v_c = cx_c;  end
            2'd2:    begin u_c = -cx_c; v_c = cy_c;  end
            2'd3:    begin u_c = cy_c;  v_c = -cx_c; end
            default: begin u_c = cx_c;  v_c = cy_c;  end
        endcase
    end

    logic                  s1_valid_q;
    logic [1:0]            s1_sel_q;
    logic [FRAME_W-1:0]    s1_frame_q;
    logic signed [C_W-1:0] s1_u_q, s1_v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
            s1_frame_q <= '0;
            s1_u_q     <= '0;
            s1_v_q     <= '0;
        end else begin
            s1_valid_q <= req_valid;
            // Payload only moves on a real request to avoid needless toggling.
            if (req_valid) begin
                s1_sel_q   <= sprite_sel;
                s1_frame_q <= frame_q;
                s1_u_q     <= u_c;
                s1_v_q     <= v_c;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: geometry tests and colour select
    // ---------------------------------------------------------------
    logic [C_W-1:0]              au_c, av_c;
    logic [SQ_W-1:0]             r2_c;
    logic                        inside_c, pellet_c, u_pos_c, mouth_c;
    logic [PIXEL_COLOR_BITS-1:0] color_c;

    assign au_c     = s1_u_q[C_W-1] ? unsigned'(-s1_u_q) : unsigned'(s1_u_q);
    assign av_c     = s1_v_q[C_W-1] ? unsigned'(-s1_v_q) : unsigned'(s1_v_q);
    assign r2_c     = SQ_W'(au_c) * SQ_W'(au_c) + SQ_W'(av_c) * SQ_W'(av_c);
    assign inside_c = (r2_c <= R2_DISC);
    assign pellet_c = (r2_c <= R2_PELLET);
    assign u_pos_c  = !s1_u_q[C_W-1] && (s1_u_q != '0);
    // Wedge half-angle grows with frame: |v|/u <= frame/(NUM_FRAMES-1).
    assign mouth_c  = u_pos_c &&
                      ((SQ_W'(av_c) * SQ_W'(NUM_FRAMES - 1)) <= (SQ_W'(au_c) * SQ_W'(s1_frame_q)));

    always_comb begin
        color_c = COLOR_BG;
        case (s1_sel_q)
            SEL_BOX:    color_c = COLOR_BOX;
            SEL_PAC:    color_c = (inside_c && !mouth_c) ? COLOR_PAC : COLOR_BG;
            SEL_PELLET: color_c = pellet_c ? COLOR_PELLET : COLOR_BG;
            default:    color_c = COLOR_BG;
        endcase
    end

    logic                        pix_valid_q;
    logic [PIXEL_COLOR_BITS-1:0] pixels_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_q <= 1'b0;
            pixels_q    <= COLOR_BG;
        end else begin
            pix_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                pixels_q <= color_c;
            end
        end
    end

    assign pix_valid = pix_valid_q;
    assign pixels    = pixels_q;

endmodule

// File: tb/tb_pacman_sprite_engine.sv
// Self-checking bench for pacman_sprite_engine: directed scenarios plus random traffic
// compared every cycle against a geometric reference model.
module tb_pacman_sprite_engine;

    localparam int PW = 16;
    localparam int NF = 4;
    localparam int FT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       anim_tick = 1'b0;
    logic       anim_en = 1'b0;
    logic [1:0] dir = '0;
    logic [1:0] sprite_sel = '0;
    logic       req_valid = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic       pix_valid;
    logic [7:0] pixels;
    logic [1:0] frame;

    int checks = 0;
    int errors = 0;

    pacman_sprite_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .anim_tick  (anim_tick),
        .anim_en    (anim_en),
        .dir        (dir),
        .sprite_sel (sprite_sel),
        .req_valid  (req_valid),
        .x          (x),
        .y          (y),
        .pix_valid  (pix_valid),
        .pixels     (pixels),
        .frame      (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference colour straight from the geometric definition, in plain integers.
    function automatic logic [7:0] model_pix(int sel, int d, int fr, int px, int py);
        int cx, cy, u, v, r2, av;
        cx = 2 * px - (PW - 1);
        cy = 2 * py - (PW - 1);
        case (d)
            1:       begin u = -cy; v = cx;  end
            2:       begin u = -cx; v = cy;  end
            3:       begin u = cy;  v = -cx; end
            default: begin u = cx;  v = cy;  end
        endcase
        r2 = u * u + v * v;
        av = (v < 0) ? -v : v;
        case (sel)
            0: return 8'h38;
            1: return ((r2 <= PW * PW) && !((u > 0) && (av * (NF - 1) <= u * fr))) ? 8'hFC : 8'h00;
            2: return (r2 <= (PW / 2) * (PW / 2)) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // Model state: two-cycle delay line of precomputed colours plus animation counters.
    int         m_tick = 0;
    int         m_frame = 0;
    logic       m_s1v = 1'b0;
    logic [7:0] m_s1p = 8'h00;
    logic       m_vout = 1'b0;
    logic [7:0] m_pout = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tick = 0; m_frame = 0;
            m_s1v = 1'b0; m_s1p = 8'h00;
            m_vout = 1'b0; m_pout = 8'h00;
        end else begin
            m_vout = m_s1v;
            if (m_s1v) m_pout = m_s1p;
            m_s1v = req_valid;
            if (req_valid) m_s1p = model_pix(int'(sprite_sel), int'(dir), m_frame, int'(x), int'(y));
            if (anim_tick && anim_en) begin
                if (m_tick == FT - 1) begin
                    m_tick = 0;
                    m_frame = (m_frame + 1) % NF;
                end else begin
                    m_tick++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_pix_valid", 32'(pix_valid), 32'(m_vout));
        chk("cyc_pixels", 32'(pixels), 32'(m_pout));
        chk("cyc_frame", 32'(frame), 32'(m_frame));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input int d, input int px, input int py);
        req_valid  = 1'b1;
        sprite_sel = 2'(sel);
        dir        = 2'(d);
        x          = 4'(px);
        y          = 4'(py);
        step();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            anim_en = 1'b1;
            anim_tick = 1'b1;
            idle();
            anim_tick = 1'b0;
            idle();
        end
    endtask

    initial begin
        // Pin the reference model against hand-worked values.
        chk("model_box",        32'(model_pix(0, 0, 0, 3, 5)),  32'h38);
        chk("model_pac_f0",     32'(model_pix(1, 0, 0, 15, 8)), 32'hFC);
        chk("model_pac_corner", 32'(model_pix(1, 0, 0, 0, 0)),  32'h00);
        chk("model_mouth_d0",   32'(model_pix(1, 0, 3, 15, 8)), 32'h00);
        chk("model_back_d2",    32'(model_pix(1, 2, 3, 15, 8)), 32'hFC);
        chk("model_mouth_d2",   32'(model_pix(1, 2, 3, 0, 8)),  32'h00);
        chk("model_mouth_d1",   32'(model_pix(1, 1, 3, 8, 0)),  32'h00);
        chk("model_mouth_d3",   32'(model_pix(1, 3, 3, 8, 15)), 32'h00);
        chk("model_pellet",     32'(model_pix(2, 0, 0, 8, 8)),  32'hFF);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_valid", 32'(pix_valid), 32'h0);
        chk("rst_pixels",    32'(pixels),    32'h00);
        chk("rst_frame",     32'(frame),     32'h0);
        rst_n = 1'b1;
        idle();

        // Single box request: latency two, then valid drops.
        send(0, 0, 3, 5);
        idle();
        chk("t1_valid", 32'(pix_valid), 32'h1);
        chk("t1_pixels", 32'(pixels), 32'h38);
        idle();
        chk("t1_valid_drop", 32'(pix_valid), 32'h0);

        send(1, 0, 15, 8);
        send(1, 0, 0, 0);
        chk("t2_pac_edge", 32'(pixels), 32'hFC);
        idle();
        chk("t2_pac_corner", 32'(pixels), 32'h00);
        idle();

        ticks(8);
        chk("t3_frame_8", 32'(frame), 32'h1);
        ticks(16);
        chk("t3_frame_24", 32'(frame), 32'h3);
        ticks(8);
        chk("t3_frame_32", 32'(frame), 32'h0);
        for (int i = 0; i < 5; i++) begin
            anim_en = 1'b0; anim_tick = 1'b1; idle();
            anim_tick = 1'b0; idle();
        end
        chk("t3_frozen", 32'(frame), 32'h0);

        ticks(24);
        chk("t4_frame3", 32'(frame), 32'h3);
        send(1, 0, 15, 8);
        send(1, 2, 15, 8);
        chk("t4_d0_mouth", 32'(pixels), 32'h00);
        send(1, 2, 0, 8);
        chk("t4_d2_back", 32'(pixels), 32'hFC);
        send(1, 1, 8, 0);
        chk("t4_d2_mouth", 32'(pixels), 32'h00);
        send(1, 3, 8, 15);
        chk("t4_d1_mouth", 32'(pixels), 32'h00);
        idle();
        chk("t4_d3_mouth", 32'(pixels), 32'h00);
        idle();

        ticks(8);
        chk("t5_frame0", 32'(frame), 32'h0);
        send(0, 0, 8, 8);
        send(1, 0, 8, 8);
        chk("t5_box", 32'(pixels), 32'h38);
        send(2, 0, 8, 8);
        chk("t5_pac", 32'(pixels), 32'hFC);
        send(3, 0, 8, 8);
        chk("t5_pellet", 32'(pixels), 32'hFF);
        idle();
        chk("t5_bg", 32'(pixels), 32'h00);
        chk("t5_valid", 32'(pix_valid), 32'h1);
        idle();

        // Random traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            anim_tick = ($urandom_range(0, 3) == 0);
            anim_en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) != 0)
                send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            else
                idle();
        end
        anim_tick = 1'b0;

        // Reset with requests in flight: nothing may emerge afterwards.
        ticks(FT);
        send(0, 0, 1, 1);
        req_valid = 1'b1; sprite_sel = 2'd2; x = 4'd8; y = 4'd8;
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_valid", 32'(pix_valid), 32'h0);
        end
        chk("t6_frame", 32'(frame), 32'h0);
        chk("t6_pixels", 32'(pixels), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
